regfile_2r1w: RTL and testbench

- 32 x 32-bit MIPS general register file for the multi-cycle CPU.
- Directly upstream of the ALU: the two read ports drive the ALU A/B operand muxes, including the shift units, which take the shift amount from A[4:0] and the data from B.
- Written back from the ALU-out/MDR writeback mux.
- A third read-only debug port feeds the board display, for register inspection via switches.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_2r1w.sv | 84 ++++++++
 tb/tb_regfile_2r1w.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS general register file: default widths and
// the architecturally named registers used by the CPU and its bench.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W_DEF-1:0] REG_AT   = 5'd1;
    localparam logic [ADDR_W_DEF-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W_DEF-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x 32 MIPS register file: two combinational operand read ports (A/B) with
// optional same-cycle write forwarding, one write port, and a committed-state
// debug read port for the board display. r0 is hardwired to zero.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    // Storage is reset as a whole, so it lives in flops rather than block RAM.
    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [15:0]       wr_count_reg;
    logic              commit;

    logic [DATA_W-1:0] ra_committed;
    logic [DATA_W-1:0] rb_committed;

    // A write only lands when it targets a real register; r0 writes vanish.
    assign commit = we && (wa_addr != ZERO_ADDR);

    // Forwarding test shared by both operand ports: the in-flight write is
    // visible early only when it will actually commit to the port's address.
    function automatic logic bypass_hit(input logic              w_en,
                                        input logic [ADDR_W-1:0] w_addr,
                                        input logic [ADDR_W-1:0] r_addr);
        return BYPASS && w_en && (w_addr != ZERO_ADDR) && (w_addr == r_addr);
    endfunction

    // Register array and write counter; reset clears everything and beats
    // any write presented on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            wr_count_reg <= '0;
        end else if (commit) begin
            regs_reg[wa_addr] <= wa_data;
            wr_count_reg      <= wr_count_reg + 16'd1;
        end
    end

    // Committed values with the r0 rule applied on every port.
    assign ra_committed = (ra_addr  == ZERO_ADDR) ? '0 : regs_reg[ra_addr];
    assign rb_committed = (rb_addr  == ZERO_ADDR) ? '0 : regs_reg[rb_addr];
    assign dbg_data     = (dbg_addr == ZERO_ADDR) ? '0 : regs_reg[dbg_addr];

    // Operand A: committed value, or the pending write data when forwarding.
    always_comb begin
        ra_data = ra_committed;
        if (bypass_hit(we, wa_addr, ra_addr)) begin
            ra_data = wa_data;
        end
    end

    // Operand B: same forwarding rule as port A.
    always_comb begin
        rb_data = rb_committed;
        if (bypass_hit(we, wa_addr, rb_addr)) begin
            rb_data = wa_data;
        end
    end

    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one instance with forwarding, one without,
// sharing the same stimulus.
module tb_regfile_2r1w;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra_addr, rb_addr, wa_addr, dbg_addr;
    logic        we;
    logic [31:0] wa_data;

    logic [31:0] ra_data, rb_data, dbg_data;
    logic [15:0] wr_count;
    logic [31:0] nb_ra_data, nb_rb_data, nb_dbg_data;
    logic [15:0] nb_wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] shifted;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .ra_data(ra_data),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .we(we), .wa_addr(wa_addr), .wa_data(wa_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .wr_count(wr_count)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .ra_data(nb_ra_data),
        .rb_addr(rb_addr), .rb_data(nb_rb_data),
        .we(we), .wa_addr(wa_addr), .wa_data(wa_data),
        .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data),
        .wr_count(nb_wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: 0x%08h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we      = 1'b1;
        wa_addr = a;
        wa_data = d;
        tick();
        we      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0;
        ra_addr = '0; rb_addr = '0; wa_addr = '0; dbg_addr = '0; wa_data = '0;
        tick();
        tick();
        ra_addr = 5'd5; dbg_addr = REG_RA;
        #1;
        check("rst_ra",       ra_data,             32'h0);
        check("rst_dbg",      dbg_data,            32'h0);
        check("rst_wr_count", {16'h0, wr_count},   32'h0);
        rst = 1'b0;
        tick();

        // Basic write/read
        write_reg(5'd5, 32'hDEADBEEF);
        ra_addr = 5'd5; rb_addr = 5'd5; dbg_addr = 5'd5;
        #1;
        check("wr5_ra",     ra_data,             32'hDEADBEEF);
        check("wr5_rb",     rb_data,             32'hDEADBEEF);
        check("wr5_dbg",    dbg_data,            32'hDEADBEEF);
        check("wr5_nb_ra",  nb_ra_data,          32'hDEADBEEF);
        check("wr5_count",  {16'h0, wr_count},   32'h1);

        // Disabled write does nothing
        we = 1'b0; wa_addr = 5'd10; wa_data = 32'h12345678;
        tick();
        dbg_addr = 5'd10;
        #1;
        check("we0_r10",    dbg_data,            32'h0);
        check("we0_count",  {16'h0, wr_count},   32'h1);

        // Zero register: no forwarding, no commit, no count
        we = 1'b1; wa_addr = REG_ZERO; wa_data = 32'hFFFFFFFF;
        ra_addr = REG_ZERO; rb_addr = REG_ZERO; dbg_addr = REG_ZERO;
        #1;
        check("r0_pre_ra",  ra_data,             32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_ra",      ra_data,             32'h0);
        check("r0_rb",      rb_data,             32'h0);
        check("r0_dbg",     dbg_data,            32'h0);
        check("r0_count",   {16'h0, wr_count},   32'h1);

        // Bypass: r7 = 0x11111111, then overwrite with forwarding visible
        write_reg(5'd7, 32'h11111111);
        we = 1'b1; wa_addr = 5'd7; wa_data = 32'h0000001F;
        ra_addr = 5'd7; rb_addr = 5'd5; dbg_addr = 5'd7;
        #1;
        check("byp_ra",     ra_data,             32'h0000001F);
        check("byp_rb_oth", rb_data,             32'hDEADBEEF);
        check("byp_dbg",    dbg_data,            32'h11111111);
        check("nobyp_ra",   nb_ra_data,          32'h11111111);
        rb_addr = 5'd7;
        #1;
        check("byp_rb",     rb_data,             32'h0000001F);
        check("nobyp_rb",   nb_rb_data,          32'h11111111);
        tick();
        we = 1'b0;
        #1;
        check("post_ra",    ra_data,             32'h0000001F);
        check("post_nb_ra", nb_ra_data,          32'h0000001F);
        check("post_dbg",   dbg_data,            32'h0000001F);
        check("post_count", {16'h0, wr_count},   32'h3);

        // Shift-operand feed
        write_reg(5'd8, 32'h00000004);
        write_reg(5'd9, 32'h80000000);
        ra_addr = 5'd8; rb_addr = 5'd9;
        #1;
        check("sh_a",       ra_data,             32'h00000004);
        check("sh_b",       rb_data,             32'h80000000);
        shifted = rb_data >> ra_data[4:0];
        check("sh_srl",     shifted,             32'h08000000);
        check("sh_count",   {16'h0, wr_count},   32'h5);

        // Async reset mid-cycle after writes: clears without an edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_count",    {16'h0, wr_count},    32'h0);
        check("arst_nb_count", {16'h0, nb_wr_count}, 32'h0);
        check("arst_ra",       ra_data,              32'h0);
        check("arst_rb",       rb_data,              32'h0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #0.1;
            check($sformatf("arst_dbg%0d", a), dbg_data, 32'h0);
        end
        tick();
        rst = 1'b0;

        // Counter wrap: 65536 non-zero writes from reset
        last_addr = '0; last_data = '0;
        for (int i = 0; i < 65536; i++) begin
            if (i == 65535) begin
                check("cnt_ffff", {16'h0, wr_count}, 32'h0000FFFF);
            end
            last_addr = 5'((i % 31) + 1);
            last_data = i;
            write_reg(last_addr, last_data);
        end
        dbg_addr = last_addr;
        #1;
        check("cnt_wrap",    {16'h0, wr_count},    32'h0);
        check("cnt_nb_wrap", {16'h0, nb_wr_count}, 32'h0);
        check("cnt_last",    dbg_data,             last_data);

        // Reset racing a write to r3: reset wins
        write_reg(5'd3, 32'h0BADF00D);
        dbg_addr = 5'd3;
        #1;
        check("race_pre_r3", dbg_data, 32'h0BADF00D);
        we = 1'b1; wa_addr = 5'd3; wa_data = 32'hAAAA5555; rst = 1'b1;
        #1;
        check("race_r3_now", dbg_data, 32'h0);
        tick();
        check("race_r3",     dbg_data,            32'h0);
        check("race_count",  {16'h0, wr_count},   32'h0);
        #2;
        rst = 1'b0; we = 1'b0;
        tick();
        check("race_r3_aft", dbg_data,            32'h0);
        check("race_cnt_aft",{16'h0, wr_count},   32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
